// File: rtl/svnseg_scanner.sv
// Multiplexed seven-segment driver: prescaled digit scan, per-digit dp/blanking, 16-level PWM.
// Optional leading-zero blanking is compiled in with SVNSEG_LZB_EN.
module svnseg_scanner #(
   parameter int NUM_DIGITS = 4,
   parameter int DIV_WIDTH  = 12
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] nums,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   input  logic [3:0]              brightness,
   output logic [NUM_DIGITS-1:0]   dig,
   output logic [6:0]              seg,
   output logic                    dp
);

   localparam int IDX_W = $clog2(NUM_DIGITS > 1 ? NUM_DIGITS : 2);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [DIV_WIDTH-1:0]  cnt;
   logic [IDX_W-1:0]      idx;
   logic                  tick;
   logic                  on;
   logic                  vis;
   logic [3:0]            cur_num;
   logic                  cur_blank;
   logic                  cur_dp;
   logic                  cur_lzb;
   logic [6:0]            glyph;
   logic [NUM_DIGITS-1:0] lzb_suppress;
   logic [NUM_DIGITS-1:0] dig_d;

   assign tick = &cnt;
   assign on   = (cnt[DIV_WIDTH-1 -: 4] <= brightness);

`ifdef SVNSEG_LZB_EN
   // A digit is suppressed when it and every digit above it are zero.
   logic above_zero;
   always_comb begin
      lzb_suppress = '0;
      above_zero   = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         above_zero      = above_zero & (nums[4*i +: 4] == 4'h0);
         lzb_suppress[i] = above_zero;
      end
   end
`else
   assign lzb_suppress = '0;
`endif

   always_comb begin
      cur_num   = 4'h0;
      cur_blank = 1'b0;
      cur_dp    = 1'b0;
      cur_lzb   = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_num   = nums[4*i +: 4];
            cur_blank = blank_mask[i];
            cur_dp    = dp_mask[i];
            cur_lzb   = lzb_suppress[i];
         end
      end
   end

   assign vis = on & ~cur_blank & ~cur_lzb;

   // Active-high {g,f,e,d,c,b,a}
   always_comb begin
      case (cur_num)
         4'h0:    glyph = 7'h3F;
         4'h1:    glyph = 7'h06;
         4'h2:    glyph = 7'h5B;
         4'h3:    glyph = 7'h4F;
         4'h4:    glyph = 7'h66;
         4'h5:    glyph = 7'h6D;
         4'h6:    glyph = 7'h7D;
         4'h7:    glyph = 7'h07;
         4'h8:    glyph = 7'h7F;
         4'h9:    glyph = 7'h6F;
         4'hA:    glyph = 7'h77;
         4'hB:    glyph = 7'h7C;
         4'hC:    glyph = 7'h39;
         4'hD:    glyph = 7'h5E;
         4'hE:    glyph = 7'h79;
         default: glyph = 7'h71;
      endcase
   end

   always_comb begin
      dig_d = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         dig_d[i] = ~(vis & (idx == IDX_W'(i)));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
         dig <= '1;
         seg <= 7'h7F;
         dp  <= 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
         if (tick) begin
            if (idx == IDX_LAST) idx <= '0;
            else                 idx <= idx + 1'b1;
         end
         dig <= dig_d;
         seg <= vis ? ~glyph : 7'h7F;
         dp  <= ~(cur_dp & vis);
      end
   end

endmodule

// File: tb/tb_svnseg_scanner.sv
// Randomized bench for svnseg_scanner (NUM_DIGITS=4, DIV_WIDTH=4) against a time-based display model.
module tb_svnseg_scanner;

   localparam int ND = 4;
   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [4*ND-1:0] nums = '0;
   logic [ND-1:0] dp_mask = '0;
   logic [ND-1:0] blank_mask = '0;
   logic [3:0]    brightness = 4'd15;
   logic [ND-1:0] dig;
   logic [6:0]    seg;
   logic          dp;

   svnseg_scanner #(.NUM_DIGITS(ND), .DIV_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .nums(nums), .dp_mask(dp_mask),
      .blank_mask(blank_mask), .brightness(brightness),
      .dig(dig), .seg(seg), .dp(dp)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int t      = 0;   // cycles elapsed since reset release
   logic [ND-1:0] exp_dig;
   logic [6:0]    exp_seg;
   logic          exp_dp;

   // For each segment a..g, bit v is set when hex value v lights that segment.
   logic [15:0] seg_sets [7] = '{16'hD7ED, 16'h279F, 16'h2FFB, 16'h7B6D,
                                 16'hFD45, 16'hDF71, 16'hEF7C};

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s t=%0d got=%h want=%h", tag, t, got, want);
   endtask

   function automatic logic [6:0] glyph_of(input logic [3:0] v);
      logic [6:0] g;
      logic [15:0] s;
      for (int k = 0; k < 7; k++) begin
         s = seg_sets[k];
         g[k] = s[v];
      end
      return g;
   endfunction

   // Expected outputs after the edge that consumes time step tt.
   task automatic model(input int tt);
      int  digit;
      int  phase;
      bit  on, lz, vis;
      digit = (tt >> DW) % ND;
      phase = tt % (1 << DW);
      on    = (phase >> (DW - 4)) <= brightness;
      lz    = 1'b0;
`ifdef SVNSEG_LZB_EN
      lz    = (digit > 0) && ((nums >> (4 * digit)) == 0);
`endif
      vis     = on && !blank_mask[digit] && !lz;
      exp_dig = vis ? ~(ND'(1) << digit) : '1;
      exp_seg = vis ? ~glyph_of(4'((nums >> (4 * digit)) & 16'hF)) : 7'h7F;
      exp_dp  = !(dp_mask[digit] && vis);
   endtask

   task automatic step();
      @(posedge clk);
      model(t);
      t++;
      @(negedge clk);
      check("dig", 16'(dig), 16'(exp_dig));
      check("seg", 16'(seg), 16'(exp_seg));
      check("dp",  16'(dp),  16'(exp_dp));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_dig", 16'(dig), 16'hF);
      check("rst_seg", 16'(seg), 16'h7F);
      check("rst_dp",  16'(dp),  16'h1);
      @(negedge clk);
      rst_n = 1'b1;
      t = 0;
   endtask

   logic [6:0] dir_seg [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
   logic [3:0] dir_dig [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   initial begin
      int lo_cnt;
      nums = 16'h1234;
      #12;
      check("rst_hold_dig", 16'(dig), 16'hF);
      check("rst_hold_seg", 16'(seg), 16'h7F);
      do_reset();

      // Plain scan of 1234 across one frame and the wrap
      for (int k = 0; k < 80; k++) begin
         step();
         if (k % 16 == 0) begin
            check("scan_dig", 16'(dig), 16'(dir_dig[(k / 16) % 4]));
            check("scan_seg", 16'(seg), 16'(dir_seg[(k / 16) % 4]));
         end
      end

      // Blanking and decimal point
      do_reset();
      blank_mask = 4'b0100;
      dp_mask    = 4'b0010;
      for (int k = 0; k < 64; k++) begin
         step();
         if (k == 20) check("dp_d1", 16'(dp), 16'h0);
         if (k == 5)  check("dp_d0", 16'(dp), 16'h1);
         if (k == 40) begin
            check("blank_dig", 16'(dig), 16'hF);
            check("blank_seg", 16'(seg), 16'h7F);
         end
      end
      blank_mask = '0;
      dp_mask    = '0;

      // PWM duty at brightness 3
      do_reset();
      brightness = 4'd3;
      lo_cnt = 0;
      for (int k = 0; k < 16; k++) begin
         step();
         if (dig != 4'hF) lo_cnt++;
      end
      check("pwm_lo", 16'(lo_cnt), 16'd4);
      brightness = 4'd15;

      // Reset mid-dwell on digit 2, cycle 7
      do_reset();
      while (t < 39) step();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_dig", 16'(dig), 16'hF);
      check("mid_rst_seg", 16'(seg), 16'h7F);
      @(negedge clk);
      rst_n = 1'b1;
      t = 0;
      for (int k = 0; k < 17; k++) begin
         step();
         if (k < 16) check("restart_d0", 16'(dig), 16'hE);
         else        check("restart_d1", 16'(dig), 16'hD);
      end

      // Randomized inputs, model-checked every cycle
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
               0: nums       = 16'($urandom);
               1: dp_mask    = 4'($urandom);
               2: blank_mask = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
               default: brightness = 4'($urandom);
            endcase
         end
         step();
      end

`ifdef SVNSEG_LZB_EN
      do_reset();
      nums = 16'h0070; blank_mask = '0; dp_mask = '0; brightness = 4'd15;
      for (int k = 0; k < 64; k++) step();
      nums = 16'h0000;
      for (int k = 0; k < 64; k++) step();
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout t=%0d", t);
      $fatal(1);
   end

endmodule

// File: doc/svnseg_scanner.md
# svnseg_scanner

Parametrised multiplexed seven-segment display driver. It time-multiplexes NUM_DIGITS hex digits onto one shared segment bus. It adds per-digit decimal points, per-digit blanking and 16-level PWM brightness, and uses a clock-enable prescaler instead of a derived clock. It sits between the game score/status logic and the board display pins.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits; legal range 1..16.
- DIV_WIDTH, 12, prescaler width; scan period per digit is 2^DIV_WIDTH clk cycles; minimum 4.
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- nums  in  4*NUM_DIGITS  hex values; digit i is nums[4*i+3:4*i], and digit 0 is rightmost.
- dp_mask  in  NUM_DIGITS  1 = decimal point lit on digit i.
- blank_mask  in  NUM_DIGITS  1 = digit i dark (segments and dp off).
- brightness  in  4  PWM level; duty = (brightness+1)/16.
- dig  out  NUM_DIGITS  digit enables, active-low, one-hot-low or all high.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

## Operation
- Prescaler `cnt` (DIV_WIDTH bits) increments every cycle and wraps. `tick` is asserted when cnt is all ones.
- Scan index `idx` (width clog2(max(NUM_DIGITS,2))):
  - On tick, idx advances by 1.
  - When idx equals NUM_DIGITS-1, the advance wraps idx to 0, so the scan is 0,1,...,NUM_DIGITS-1,0,...
  - For NUM_DIGITS=1, idx stays 0.
- PWM gate `on`:
  - on = (cnt[DIV_WIDTH-1:DIV_WIDTH-4] <= brightness).
  - brightness 15 is always on. Brightness 0 gives 1/16 duty.
- Visibility `vis` = on AND NOT blank_mask[idx] AND NOT lzb_suppress[idx]. lzb_suppress is all zero unless SVNSEG_LZB_EN is defined.
- Internal hex decoder uses standard glyphs, active-high a..g before inversion. Examples:
  - 0 lights a-f.
  - 1 lights b,c.
  - 8 lights all segments.
  - A lights a,b,c,e,f,g.
  - b lights c,d,e,f,g.
  - F lights a,e,f,g.
- Registered outputs, updated every cycle:
  - dig: bit idx = ~vis, all other bits 1.
  - seg: ~glyph(nums[idx]) if vis, else 7'h7F.
  - dp: ~(dp_mask[idx] & vis).
- Inputs are sampled live every cycle. An input change appears on the outputs one cycle later, with no need to wait for a scan tick.
- At most one dig bit is ever low.

## Timing
- Reset values (asynchronous): cnt=0, idx=0, dig=all 1, seg=7'h7F, dp=1.
- Output latency: one clk from any input or state change.
- idx changes on the clock edge where tick=1. The output register reflects the new digit one cycle after that edge.
- Digit dwell is exactly 2^DIV_WIDTH cycles. The full frame is NUM_DIGITS*2^DIV_WIDTH cycles.
- Reset asserted mid-scan forces all outputs dark immediately. After deassertion, scanning restarts at digit 0 with cnt=0.
- A brightness change takes effect on the next cycle's comparison. There is no glitch beyond that one-cycle latency.
- blank_mask and dp_mask changes take effect one cycle after the change, even mid-dwell.

## Configuration
- SVNSEG_LZB_EN:
  - Defined: leading-zero blanking. Digit i (i>0) is suppressed when it and all digits above it are 0. Digit 0 is never suppressed. Suppression is evaluated combinationally from nums each cycle and gates dp as well.
  - Undefined: the logic is absent, lzb_suppress=0, and every non-blanked digit is displayed including zeros.

## Test plan
All scenarios use NUM_DIGITS=4, DIV_WIDTH=4 and brightness=15 unless stated.
- Reset then release with nums=16'h1234 -> outputs dark during reset. Afterwards:
  - Digit 0: dig=4'b1110, seg=7'b0011001 ('4') for 16 cycles.
  - Then digits 1,2,3 with '3','2','1' in turn.
  - After digit 3, wrap to dig=4'b1110.
- blank_mask=4'b0100 and dp_mask=4'b0010 -> during the digit 2 dwell, dig=4'b1111 and seg=7'h7F. During digit 1, dp=0. During all other digits, dp=1.
- brightness=3 -> within each 16-cycle dwell, dig is low for exactly 4 cycles (cnt 0-3) and high for 12.
- Reset asserted on cycle 7 of the digit 2 dwell -> dig=4'b1111 asynchronously. After release, the first active digit is 0 and its dwell lasts 16 cycles.
- SVNSEG_LZB_EN defined, nums=16'h0070 -> digits 3 and 2 are dark, digit 1 shows '7' (seg=7'b1111000), digit 0 shows '0' (seg=7'b1000000). With nums=0, only digit 0 shows '0'.
- NUM_DIGITS=1 -> idx stays 0 and dig=1'b0 continuously at brightness 15. A change to nums appears on seg exactly one cycle later.
